uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one 8N1 UART transmit line among several byte producers in the UART subsystem. Each requester presents a byte with a request. The block grants one requester at a time, latches its byte, and serialises the frame on `TX` at a fixed baud rate. It owns the baud timing, so requesters never see bit-level timing.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); minimum 2.

Ports:
- `CLK50M` in 1: the single system clock; all logic is on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `req` in `N_REQ`: per-requester request; level-held until acked.
- `data` in `8*N_REQ`: byte of requester i is at `data[8*i+7 : 8*i]`; must be stable while `req[i]` is high.
- `ack` out `N_REQ`: one-cycle pulse to the granted requester when its byte is latched.
- `busy` out 1: high whenever a frame is in progress (START, DATA or STOP).
- `grant_id` out `$clog2(N_REQ)`: index of the last granted requester; holds between frames.
- `TX` out 1: serial line, idle high.

## Operation
- States:
  - IDLE: `TX`=1, `busy`=0.
  - START: `TX`=0 for one bit time.
  - DATA: 8 bits, LSB first, one bit time each.
  - STOP: `TX`=1 for one bit time.
- From STOP the block returns to IDLE.
- IDLE and `req`≠0: pick the winner by round robin, starting the search at `ptr`, wrapping from `N_REQ-1` to 0. In the same edge:
  - latch the winner's byte into the shift register;
  - pulse `ack[winner]`;
  - set `grant_id`=winner and `ptr`=(winner+1) mod `N_REQ`;
  - enter START.
- IDLE and `req`=0: stay in IDLE; `ptr` is unchanged.
- Requests that arrive or are dropped during a frame are ignored until the next IDLE cycle. A request withdrawn before ack is never granted and never acked.
- If a requester holds `req` high after its ack, that is a new request for its current `data`. Round robin still serves all other pending requesters first.
- Bit counter: 0..7, wraps to 0 on leaving DATA.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits. It counts 0..`CLKS_PER_BIT-1` and wraps; each wrap ends a bit.
- `data` is sampled only at the grant edge. Later changes to `data` do not affect the frame.

## Timing
- Reset values: `TX`=1, `ack`=0, `busy`=0, `grant_id`=0, `ptr`=0, state IDLE, all counters 0.
- Grant latency: `req` high and sampled in IDLE at edge t → at t+1 (registered outputs) `ack`=1 for exactly one cycle, `TX`=0, `busy`=1.
- Frame length: exactly `10*CLKS_PER_BIT` cycles of `busy`=1.
  - START bit spans cycles t+1 .. t+`CLKS_PER_BIT`.
  - Data bit k spans cycles starting at t+1+(k+1)·`CLKS_PER_BIT`.
  - STOP bit is the final `CLKS_PER_BIT` cycles.
- After STOP the block spends at least one IDLE cycle with `busy`=0 and `TX`=1. Back-to-back frame period is therefore `10*CLKS_PER_BIT+1` cycles.
- Simultaneous requests in one IDLE cycle: exactly one ack is pulsed, to the round-robin winner.
- `RST` asserted mid-frame: `TX` goes to 1 and `ack`/`busy` go to 0 immediately, without waiting for a clock edge. The frame is abandoned. After `RST` deasserts, the first grant uses `ptr`=0.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS`=8;
  - `UART_DEFAULT_CLKS_PER_BIT`=434.
- One sub-module, `rr_arbiter`: a combinational round-robin pick from `req` and `ptr`, outputting `valid` and `winner`.
- The shift register, baud counter, bit counter and FSM live in `uart_tx_sched`.

## Test plan
All scenarios use `N_REQ`=4 and `CLKS_PER_BIT`=4.
- Reset: `RST` pulsed mid-frame → `TX`=1 and `busy`=0 asynchronously. After release, `grant_id`=0; with `req`=4'b0000 the line stays idle.
- Single byte: `req`=4'b0100, `data[23:16]`=8'h61 → one cycle later `ack`=4'b0100 for 1 cycle and `grant_id`=2. `TX` carries 0,1,0,0,0,0,1,1,0,1, each held 4 cycles. `busy` is high for 40 cycles.
- Fairness: all four `req` held high continuously → grants occur in order 0,1,2,3,0. Consecutive acks are 41 cycles apart.
- Wrap-around: after granting 3, pulse `req`=4'b1001 → 0 is granted before 3.
- Withdrawn request: `req[1]` raised and dropped during a frame → no `ack[1]`, and `req[1]` has no effect on the next grant.
- Data stability: `data[7:0]` changed from 8'hA5 to 8'h00 in the cycle after `ack[0]` → the serialised byte is still 8'hA5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit subsystem: frame FSM states and
// default timing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request found when scanning
// upward from ptr, wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] winner
);

    localparam int IDW = $clog2(N_REQ);

    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one 8N1 UART transmit line among N_REQ byte producers, granting
// them round robin and serialising each granted byte at a fixed baud rate.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                     CLK50M,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     TX
);

    localparam int IDW  = $clog2(N_REQ);
    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int BITW = $clog2(UART_DATA_BITS);

    uart_state_t                  state_reg, state_next;
    logic [BW-1:0]                baud_reg, baud_next;
    logic [BITW-1:0]              bit_reg, bit_next;
    logic [UART_DATA_BITS-1:0]    shift_reg, shift_next;
    logic [IDW-1:0]               ptr_reg, ptr_next;
    logic [IDW-1:0]               gid_reg, gid_next;
    logic [N_REQ-1:0]             ack_reg, ack_next;
    logic                         tx_reg, tx_next;

    logic                         arb_valid;
    logic [IDW-1:0]               arb_winner;
    logic                         baud_wrap;
    logic [UART_DATA_BITS-1:0]    data_bytes [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
            assign data_bytes[gi] = data[8*gi +: 8];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_reg),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    assign baud_wrap = (baud_reg == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        ptr_next   = ptr_reg;
        gid_next   = gid_reg;
        ack_next   = '0;
        tx_next    = tx_reg;

        case (state_reg)
            IDLE: begin
                tx_next   = 1'b1;
                baud_next = '0;
                if (arb_valid) begin
                    shift_next           = data_bytes[arb_winner];
                    ack_next[arb_winner] = 1'b1;
                    gid_next             = arb_winner;
                    ptr_next             = (arb_winner == IDW'(N_REQ - 1)) ? '0 : arb_winner + IDW'(1);
                    state_next           = START;
                    tx_next              = 1'b0;
                end
            end
            START, DATA, STOP: begin
                baud_next = baud_wrap ? '0 : baud_reg + BW'(1);
                if (baud_wrap) begin
                    case (state_reg)
                        START: begin
                            state_next = DATA;
                            tx_next    = shift_reg[0];
                        end
                        DATA: begin
                            if (bit_reg == BITW'(UART_DATA_BITS - 1)) begin
                                bit_next   = '0;
                                state_next = STOP;
                                tx_next    = 1'b1;
                            end else begin
                                // Shift first so tx always reflects shift_reg[0] during a data bit.
                                bit_next   = bit_reg + BITW'(1);
                                shift_next = shift_reg >> 1;
                                tx_next    = shift_reg[1];
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            ptr_reg   <= '0;
            gid_reg   <= '0;
            ack_reg   <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            ptr_reg   <= ptr_next;
            gid_reg   <= gid_next;
            ack_reg   <= ack_next;
            tx_reg    <= tx_next;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign ack      = ack_reg;
    assign grant_id = gid_reg;
    assign TX       = tx_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with N_REQ=4, CLKS_PER_BIT=4: a frame-position model
// checked every cycle, plus directed scenarios with hand-computed frames.
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int C     = 4;
    localparam int FRAME = 10 * C;

    logic        CLK50M = 1'b0;
    logic        RST    = 1'b1;
    logic [3:0]  req    = '0;
    logic [31:0] data   = '0;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        TX;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ack1_cnt = 0;

    uart_tx_sched #(
        .N_REQ        (N),
        .CLKS_PER_BIT (C)
    ) dut (
        .CLK50M   (CLK50M),
        .RST      (RST),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .TX       (TX)
    );

    always #5 CLK50M = ~CLK50M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: m_pos counts cycles into the current frame (0 = idle, 1..FRAME = in frame).
    int         m_pos  = 0;
    int         m_ptr  = 0;
    int         m_win  = 0;
    int         m_gid  = 0;
    logic [7:0] m_byte = '0;

    always @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            m_pos = 0;
            m_ptr = 0;
            m_gid = 0;
            m_win = 0;
        end else begin
            cyc++;
            if (m_pos == 0) begin
                if (req != 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (req[(m_ptr + k) % N]) begin
                            m_win = (m_ptr + k) % N;
                            break;
                        end
                    end
                    m_byte = data[8*m_win +: 8];
                    m_gid  = m_win;
                    m_ptr  = (m_win + 1) % N;
                    m_pos  = 1;
                end
            end else if (m_pos == FRAME) begin
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge CLK50M) begin
        int         k;
        logic       etx;
        logic [3:0] eack;
        if (ack[1]) ack1_cnt++;
        if (!RST) begin
            eack = (m_pos == 1) ? 4'(1 << m_win) : 4'b0;
            if (m_pos == 0) begin
                etx = 1'b1;
            end else begin
                k = (m_pos - 1) / C;
                if (k == 0)      etx = 1'b0;
                else if (k <= 8) etx = m_byte[k-1];
                else             etx = 1'b1;
            end
            check("model_tx",   TX,       etx);
            check("model_busy", busy,     m_pos != 0);
            check("model_ack",  ack,      eack);
            check("model_gid",  grant_id, m_gid);
        end
    end

    task automatic wait_ack(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK50M);
            if (ack != 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no ack required one within 200 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(negedge CLK50M);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still 1 required 0 (cycle %0d)", cyc);
        end
    endtask

    // ebits[0] is the start bit, ebits[9] the stop bit.
    task automatic run_frame(input string tag, input logic [3:0] eack, input logic [1:0] eid,
                             input logic [9:0] ebits, input logic [3:0] req_after,
                             input logic [31:0] data_after);
        bit         ok;
        logic [9:0] got;
        int         busy_n;
        wait_ack(ok);
        if (!ok) return;
        check({tag, "_ack"}, ack, eack);
        check({tag, "_gid"}, grant_id, eid);
        req    = req_after;
        data   = data_after;
        got    = '0;
        busy_n = 0;
        for (int j = 1; j <= 60; j++) begin
            if (j > 1) @(negedge CLK50M);
            if (!busy) break;
            busy_n++;
            if (j % C == 2) got[(j - 2) / C] = TX;
        end
        check({tag, "_bits"}, got, ebits);
        check({tag, "_busy_cycles"}, busy_n, FRAME);
    endtask

    initial begin
        bit ok;
        int ack_cyc [5];
        int ack_id  [5];
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        int a1_before;

        RST = 1'b1;
        repeat (3) @(negedge CLK50M);
        RST = 1'b0;
        @(negedge CLK50M);
        check("reset_tx",   TX,       1);
        check("reset_busy", busy,     0);
        check("reset_ack",  ack,      0);
        check("reset_gid",  grant_id, 0);

        // Asynchronous reset during the START bit of a frame granted to requester 1.
        req  = 4'b0010;
        data = 32'h0000_3300;
        wait_ack(ok);
        req = 4'b0000;
        check("pre_rst_gid", grant_id, 1);
        #2 RST = 1'b1;
        #1;
        check("async_rst_tx",   TX,   1);
        check("async_rst_busy", busy, 0);
        check("async_rst_ack",  ack,  0);
        @(negedge CLK50M);
        @(negedge CLK50M);
        RST = 1'b0;
        @(negedge CLK50M);
        check("post_rst_gid", grant_id, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK50M);
            check("idle_busy", busy, 0);
            check("idle_tx",   TX,   1);
        end

        // Fairness with all requests held.
        data = 32'h4433_2211;
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(ok);
            ack_cyc[i] = cyc;
            ack_id[i]  = grant_id;
            check("fair_id", ack_id[i], exp_ids[i]);
            if (i > 0) check("fair_gap", ack_cyc[i] - ack_cyc[i-1], 41);
        end
        req = 4'b0000;
        wait_idle();

        // Single byte 0x61 from requester 2.
        data = 32'h8061_0001;
        req  = 4'b0100;
        run_frame("single", 4'b0100, 2'd2, {1'b1, 8'h61, 1'b0}, 4'b0000, data);

        // Wrap-around: grant 3, then 0 is served before 3 again.
        req = 4'b1000;
        run_frame("wrap_a3", 4'b1000, 2'd3, {1'b1, 8'h80, 1'b0}, 4'b0000, data);
        req = 4'b1001;
        run_frame("wrap_b0", 4'b0001, 2'd0, {1'b1, 8'h01, 1'b0}, 4'b1000, data);
        run_frame("wrap_c3", 4'b1000, 2'd3, {1'b1, 8'h80, 1'b0}, 4'b0000, data);

        // Withdrawn request: req[1] pulsed only while a frame is in progress.
        a1_before = ack1_cnt;
        data = 32'h8061_003C;
        req  = 4'b0001;
        wait_ack(ok);
        check("wd_gid", grant_id, 0);
        req = 4'b0000;
        repeat (8) @(negedge CLK50M);
        req = 4'b0010;
        repeat (8) @(negedge CLK50M);
        req = 4'b0000;
        wait_idle();
        req = 4'b0100;
        run_frame("wd_next", 4'b0100, 2'd2, {1'b1, 8'h61, 1'b0}, 4'b0000, data);
        check("wd_no_ack1", ack1_cnt - a1_before, 0);

        // Data changed right after the ack must not affect the frame.
        data = 32'h0000_00A5;
        req  = 4'b0001;
        run_frame("stable", 4'b0001, 2'd0, {1'b1, 8'hA5, 1'b0}, 4'b0000, 32'h0000_0000);

        repeat (5) @(negedge CLK50M);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
